qam16_map: RTL and testbench
============================

Name: qam16_map

Overview:
- Serial-to-symbol 16-QAM mapper in the OFDM baseband transmit chain. Sits after the interleaver and before IFFT subcarrier placement.
- Accepts one coded bit per clock while din_valid is high. Groups bits into 4-bit nibbles and maps each nibble, Gray-coded per IEEE 802.11a, to one signed I/Q constellation point.
- Tags each output symbol with its data-subcarrier index, 0..47.

Parameters:
- DATA_W, 16, width of the two's-complement I and Q outputs.
- NUM_SC, 48, data subcarriers per OFDM symbol; dout_index wraps at NUM_SC-1.
- AMP_LO, 5181, inner-level magnitude: round(16384/sqrt(10)), Q2.14.
- AMP_HI, 15543, outer-level magnitude: round(3*16384/sqrt(10)), Q2.14.

Ports:
- qam_clk  in  1  system clock, 100 MHz; all logic on its rising edge.
- qam_rst_n  in  1  reset, synchronous and active-high (1 = reset), sampled on the qam_clk rising edge.
- qam_din  in  1  serial coded bit; valid when din_valid=1.
- din_valid  in  1  qualifies qam_din; one bit per cycle while high.
- dout_valid  out  1  one-cycle pulse marking a new symbol on the data outputs.
- qam_dout_real  out  DATA_W  signed I component.
- qam_dout_imag  out  DATA_W  signed Q component.
- dout_index  out  6  data-subcarrier index of the current symbol, 0..NUM_SC-1.

Behaviour:
- Reset (qam_rst_n=1 at a clock edge) clears the following: bit counter 0, shift register 0, dout_valid 0, qam_dout_real 0, qam_dout_imag 0, dout_index 0, symbol counter 0. Reset overrides all other activity, including a partially collected nibble.
- Bit collection:
  - On each edge with din_valid=1, qam_din is shifted into a 3-bit register and the 2-bit bit counter increments.
  - Bit order in time: b0 first, then b1, b2, b3.
- Symbol completion:
  - On the edge where din_valid=1 and the bit counter is 3, the nibble {b0,b1,b2,b3} is taken from the three stored bits plus the incoming qam_din.
  - In that same edge the outputs are registered: dout_valid=1, I/Q updated, dout_index = current symbol count.
  - Latency: the outputs are visible one clock edge after b3 is presented, i.e. registered on the edge that samples b3.
- Mapping, I from b0b1 and Q from b2b3 (Gray):
  - 00 -> -AMP_HI
  - 01 -> -AMP_LO
  - 11 -> +AMP_LO
  - 10 -> +AMP_HI
- Example nibble values:
  - b0b1b2b3 = 0000 gives I = Q = -15543 (16'hC349).
  - 1010 gives I = Q = +15543 (16'h3CB7).
- dout_valid is high for exactly one cycle per symbol. It is 0 in all other cycles.
- qam_dout_real, qam_dout_imag and dout_index hold their last values between symbols.
- Symbol counter:
  - Increments after each emitted symbol.
  - Wraps 47 -> 0.
  - Cleared only by reset; it is not cleared by din_valid gaps.
- din_valid deasserted mid-nibble: the bit counter is cleared to 0 and the partial bits are discarded (no symbol is emitted). Collection restarts at b0 on the next valid cycle.
- din_valid low with the counter at 0: no state change except that dout_valid=0.
- No backpressure: a symbol is emitted every 4 valid cycles, so the maximum output rate is qam_clk/4.
- Implementation footprint: no arithmetic beyond the counters; the mapping is a constant lookup.

Test Plan:
- Reset: hold qam_rst_n=1 for 10 cycles with din_valid toggling -> dout_valid=0, I=Q=0, dout_index=0 throughout.
- Constellation sweep: feed the 16 nibbles 0000..1111 (64 bits) -> 16 dout_valid pulses, spaced 4 cycles apart; each I/Q pair matches the table (e.g. 0111 -> I=-5181, Q=+5181; 1101 -> I=+5181, Q=-5181).
- Full OFDM symbol: 192 continuous valid bits -> 48 pulses, dout_index 0..47; the 49th symbol (next burst) carries index 0.
- Two bursts: 192 valid bits, 128 idle cycles, 192 valid bits -> 96 symbols total; no pulses during the gap; the second burst indices restart at 0 via wrap; outputs hold during the gap.
- Partial nibble: 2 valid bits, din_valid low for 1 cycle, then 4 valid bits 1010 -> exactly one pulse, I=Q=+15543.
- Mid-operation reset: assert reset after 2 bits of a nibble -> all outputs 0 next edge; subsequent nibble 0000 -> I=Q=-15543, dout_index=0.

Source files
------------

// File: rtl/qam16_map.sv
// qam16_map: serial bits -> Gray 16-QAM I/Q (802.11a) tagged with subcarrier index; qam_clk, qam_rst_n (active-high sync), qam_din/din_valid in; dout_valid, qam_dout_real/imag, dout_index out
module qam16_map #(
  parameter int DATA_W = 16,
  parameter int NUM_SC = 48,
  parameter int AMP_LO = 5181,
  parameter int AMP_HI = 15543
) (
  input  logic                     qam_clk,
  input  logic                     qam_rst_n,
  input  logic                     qam_din,
  input  logic                     din_valid,
  output logic                     dout_valid,
  output logic signed [DATA_W-1:0] qam_dout_real,
  output logic signed [DATA_W-1:0] qam_dout_imag,
  output logic [5:0]               dout_index
);
  localparam logic signed [DATA_W-1:0] LO_P = DATA_W'(AMP_LO);
  localparam logic signed [DATA_W-1:0] LO_N = DATA_W'(-AMP_LO);
  localparam logic signed [DATA_W-1:0] HI_P = DATA_W'(AMP_HI);
  localparam logic signed [DATA_W-1:0] HI_N = DATA_W'(-AMP_HI);
  logic [1:0] bit_cnt;
  logic [2:0] sr;
  logic [5:0] sym_cnt;
  logic [3:0] nib;
  logic       done;
  function automatic logic signed [DATA_W-1:0] lvl(input logic [1:0] b);
    return b[0] ? (b[1] ? LO_P : LO_N) : (b[1] ? HI_P : HI_N);
  endfunction
  assign nib  = {sr, qam_din};
  assign done = din_valid && bit_cnt == 2'd3;
  always_ff @(posedge qam_clk) begin
    if (qam_rst_n) begin
      bit_cnt       <= '0;
      sr            <= '0;
      sym_cnt       <= '0;
      dout_valid    <= 1'b0;
      qam_dout_real <= '0;
      qam_dout_imag <= '0;
      dout_index    <= '0;
    end else begin
      dout_valid <= done;
      bit_cnt    <= din_valid ? bit_cnt + 2'd1 : 2'd0;
      if (din_valid) sr <= {sr[1:0], qam_din};
      if (done) begin
        qam_dout_real <= lvl(nib[3:2]);
        qam_dout_imag <= lvl(nib[1:0]);
        dout_index    <= sym_cnt;
        sym_cnt       <= sym_cnt == 6'(NUM_SC - 1) ? 6'd0 : sym_cnt + 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_qam16_map.sv
// tb_qam16_map: scoreboard bench for qam16_map
module tb_qam16_map;
  logic        qam_clk, qam_rst_n, qam_din, din_valid;
  logic        dout_valid;
  logic [15:0] qam_dout_real, qam_dout_imag;
  logic [5:0]  dout_index;
  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [5:0]  idx;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t last;
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mcnt = 0;
  logic [3:0] mnib = '0;
  logic [5:0] midx = '0;
  qam16_map dut (
    .qam_clk(qam_clk),
    .qam_rst_n(qam_rst_n),
    .qam_din(qam_din),
    .din_valid(din_valid),
    .dout_valid(dout_valid),
    .qam_dout_real(qam_dout_real),
    .qam_dout_imag(qam_dout_imag),
    .dout_index(dout_index)
  );
  initial qam_clk = 1'b0;
  always #5 qam_clk = ~qam_clk;
  always @(posedge qam_clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [15:0] lv(input logic [1:0] b);
    case (b)
      2'b00:   return 16'hC349;
      2'b01:   return 16'hEBC3;
      2'b11:   return 16'h143D;
      default: return 16'h3CB7;
    endcase
  endfunction
  task automatic drive(input logic v, input logic b);
    @(posedge qam_clk);
    #1;
    din_valid = v;
    qam_din = b;
    if (!v) mcnt = 0;
    else begin
      mnib = {mnib[2:0], b};
      mcnt++;
      if (mcnt == 4) begin
        last = '{lv(mnib[3:2]), lv(mnib[1:0]), midx, cyc + 1};
        q.push_back(last);
        midx = midx == 6'd47 ? 6'd0 : midx + 6'd1;
        mcnt = 0;
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_re"}, 32'(qam_dout_real), 32'd0);
    chk({tag, "_im"}, 32'(qam_dout_imag), 32'd0);
    chk({tag, "_idx"}, 32'(dout_index), 32'd0);
  endtask
  task automatic rst_cycle(input string tag);
    @(posedge qam_clk);
    #1;
    qam_rst_n = 1'b1;
    din_valid = 1'b0;
    mcnt = 0;
    midx = '0;
    @(posedge qam_clk);
    @(negedge qam_clk);
    chk_zero(tag);
    @(posedge qam_clk);
    #1;
    qam_rst_n = 1'b0;
  endtask
  task automatic burst(input int nbits);
    for (int i = 0; i < nbits; i++) drive(1'b1, 1'($urandom_range(1)));
  endtask
  always @(negedge qam_clk) begin
    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("valid", 32'(dout_valid), 32'd1);
      chk("re", 32'(qam_dout_real), 32'(e.re));
      chk("im", 32'(qam_dout_imag), 32'(e.im));
      chk("idx", 32'(dout_index), 32'(e.idx));
    end else if (dout_valid !== 1'b0) chk("spurious", 32'(dout_valid), 32'd0);
  end
  initial begin
    qam_rst_n = 1'b1;
    din_valid = 1'b0;
    qam_din = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge qam_clk);
      #1;
      din_valid = 1'(i);
      qam_din = 1'(i >> 1);
      @(negedge qam_clk);
      chk_zero("reset");
    end
    @(posedge qam_clk);
    #1;
    din_valid = 1'b0;
    qam_rst_n = 1'b0;
    for (int n = 0; n < 16; n++)
      for (int k = 3; k >= 0; k--) drive(1'b1, 1'(n >> k));
    idle(3);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    rst_cycle("midrst");
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0);
    idle(3);
    rst_cycle("rst_full");
    burst(192);
    idle(2);
    burst(4);
    idle(3);
    rst_cycle("rst_burst");
    burst(192);
    idle(128);
    @(negedge qam_clk);
    chk("hold_valid", 32'(dout_valid), 32'd0);
    chk("hold_re", 32'(qam_dout_real), 32'(last.re));
    chk("hold_im", 32'(qam_dout_imag), 32'(last.im));
    chk("hold_idx", 32'(dout_index), 32'(last.idx));
    burst(192);
    idle(3);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    idle(1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    idle(4);
    chk("pending", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
